mvu_rdc_arbiter: RTL and testbench

//  Round-robin arbiter that shares one MVU data-RAM read port (rdc_en/rdc_addr/rdc_word) among NREQ requesters
//  (pito host read, output DMA, debug tap, ...).

---
 rtl/mvu_rdc_arbiter_if.sv | 30 +++
 rtl/mvu_rdc_arbiter.sv | 92 +++++++++
 tb/tb_mvu_rdc_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mvu_rdc_arbiter_if.sv
// Bundle of requester, RAM read-port and response signals around one MVU rdc arbiter.
// Handshake: a requester holds req_en (and may update req_addr) until req_grnt for it is high in the same cycle;
// the word comes back on rsp_valid/rsp_word exactly RD_LAT cycles later, with no backpressure on responses.
interface mvu_rdc_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 64
);
    logic [NREQ-1:0]        req_en;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ-1:0]        prio_mask;
    logic                   stall;
    logic [NREQ-1:0]        req_grnt;
    logic                   mem_rd_en;
    logic [ADDR_W-1:0]      mem_rd_addr;
    logic [DATA_W-1:0]      mem_rd_word;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_word;
    logic                   busy;

    modport master (
        output req_en, req_addr, prio_mask, stall, mem_rd_word,
        input  req_grnt, mem_rd_en, mem_rd_addr, rsp_valid, rsp_word, busy
    );

    modport slave (
        input  req_en, req_addr, prio_mask, stall, mem_rd_word,
        output req_grnt, mem_rd_en, mem_rd_addr, rsp_valid, rsp_word, busy
    );
endinterface

// File: rtl/mvu_rdc_arbiter.sv
// Round-robin arbiter sharing one MVU data-RAM read port among NREQ requesters, with a
// RD_LAT-deep tag pipeline that steers each returned word back to the requester that issued it.
module mvu_rdc_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    mvu_rdc_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  prio_req;
    logic [NREQ-1:0]  cand;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] scan_idx;
    logic             found;
    logic             grant;
    int               scan_pos;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [IDX_W-1:0]  tag_idx_q [RD_LAT];

    // High-priority class wins outright; round-robin scan starts at ptr and wraps below NREQ.
    always_comb begin
        prio_req = bus.req_en & bus.prio_mask;
        cand     = (|prio_req) ? prio_req : bus.req_en;
        win      = '0;
        found    = 1'b0;
        scan_pos = 0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_pos = int'(ptr_q) + k;
            if (scan_pos >= NREQ) begin
                scan_pos = scan_pos - NREQ;
            end
            scan_idx = IDX_W'(scan_pos);
            if (!found && cand[scan_idx]) begin
                found = 1'b1;
                win   = scan_idx;
            end
        end
        grant = !rst && !bus.stall && found;
    end

    always_comb begin
        bus.req_grnt    = '0;
        bus.mem_rd_en   = grant;
        bus.mem_rd_addr = '0;
        ptr_d           = ptr_q;
        if (grant) begin
            bus.req_grnt    = NREQ'(1) << win;
            bus.mem_rd_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
            ptr_d           = (win == IDX_W'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    // Response side is purely combinational off the last tag stage; the RAM word is passed straight through.
    always_comb begin
        bus.rsp_valid = '0;
        bus.rsp_word  = '0;
        bus.busy      = 1'b0;
        if (!rst) begin
            if (tag_vld_q[RD_LAT-1]) begin
                bus.rsp_valid = NREQ'(1) << tag_idx_q[RD_LAT-1];
            end
            bus.rsp_word = bus.mem_rd_word;
            bus.busy     = |tag_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            tag_vld_q <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_idx_q[s] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            tag_vld_q[0] <= grant;
            tag_idx_q[0] <= win;
            for (int s = 1; s < RD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_idx_q[s] <= tag_idx_q[s-1];
            end
        end
    end
endmodule

// File: tb/tb_mvu_rdc_arbiter.sv
// Bench for mvu_rdc_arbiter: two instances (RD_LAT 2 and 4) share one stimulus stream and are
// checked every cycle against a cycle-indexed schedule model plus a table of expected grants.
module tb_mvu_rdc_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 15;
    localparam int DW   = 64;
    localparam int LA   = 2;
    localparam int LB   = 4;
    localparam int MAXC = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_en;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    prio;
    logic               stall;
    logic [DW-1:0]      word_in [2];

    mvu_rdc_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) if_a ();
    mvu_rdc_arbiter_if #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) if_b ();

    mvu_rdc_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LA)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    mvu_rdc_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(LB)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));

    assign if_a.req_en      = req_en;
    assign if_a.req_addr    = req_addr;
    assign if_a.prio_mask   = prio;
    assign if_a.stall       = stall;
    assign if_a.mem_rd_word = word_in[0];
    assign if_b.req_en      = req_en;
    assign if_b.req_addr    = req_addr;
    assign if_b.prio_mask   = prio;
    assign if_b.stall       = stall;
    assign if_b.mem_rd_word = word_in[1];

    logic [NREQ-1:0] grnt_o [2];
    logic            en_o   [2];
    logic [AW-1:0]   addr_o [2];
    logic [NREQ-1:0] rsp_o  [2];
    logic [DW-1:0]   word_o [2];
    logic            busy_o [2];
    assign grnt_o[0] = if_a.req_grnt;    assign grnt_o[1] = if_b.req_grnt;
    assign en_o[0]   = if_a.mem_rd_en;   assign en_o[1]   = if_b.mem_rd_en;
    assign addr_o[0] = if_a.mem_rd_addr; assign addr_o[1] = if_b.mem_rd_addr;
    assign rsp_o[0]  = if_a.rsp_valid;   assign rsp_o[1]  = if_b.rsp_valid;
    assign word_o[0] = if_a.rsp_word;    assign word_o[1] = if_b.rsp_word;
    assign busy_o[0] = if_a.busy;        assign busy_o[1] = if_b.busy;

    // Reference model: per-cycle schedule of expected responses and of RAM returns.
    int            lat [2];
    int            sched_idx  [2][MAXC];
    logic [AW-1:0] sched_addr [2][MAXC];
    logic          ram_vld    [2][MAXC];
    logic [AW-1:0] ram_addr   [2][MAXC];
    int            m_ptr;
    int            cyc;
    int            n_checks;
    int            n_pass;
    int            rsp_cnt_b;
    int            last_rsp_b;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0000_00A5_0000_005A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic step(input logic use_exp, input logic [NREQ-1:0] exp_g, input string tag);
        logic [NREQ-1:0] cand;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] ev;
        logic [AW-1:0]   ea;
        logic            grant_e;
        logic            busy_e;
        int              w;
        int              p;
        for (int d = 0; d < 2; d++) begin
            word_in[d] = ram_vld[d][cyc] ? word_of(ram_addr[d][cyc]) : {$urandom, $urandom};
        end
        #1;
        cand = ((req_en & prio) != 0) ? (req_en & prio) : req_en;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            p = (m_ptr + k) % NREQ;
            if (w < 0 && cand[p]) w = p;
        end
        grant_e = !rst && !stall && (w >= 0);
        eg = grant_e ? NREQ'(1 << w) : '0;
        ea = grant_e ? req_addr[w*AW +: AW] : '0;
        if (use_exp) check({tag, " table_grant"}, grnt_o[0], exp_g);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("grant_d%0d", d), grnt_o[d], eg);
            check($sformatf("rd_en_d%0d", d), en_o[d], grant_e);
            if (grant_e || rst) check($sformatf("rd_addr_d%0d", d), addr_o[d], ea);
            ev = (!rst && sched_idx[d][cyc] >= 0) ? NREQ'(1 << sched_idx[d][cyc]) : '0;
            check($sformatf("rsp_valid_d%0d", d), rsp_o[d], ev);
            if (ev != 0) check($sformatf("rsp_word_d%0d", d), word_o[d], word_of(sched_addr[d][cyc]));
            if (rst) check($sformatf("rsp_word_rst_d%0d", d), word_o[d], 64'h0);
            busy_e = 1'b0;
            if (!rst) begin
                for (int c = cyc; c < cyc + lat[d]; c++) begin
                    if (sched_idx[d][c] >= 0) busy_e = 1'b1;
                end
            end
            check($sformatf("busy_d%0d", d), busy_o[d], busy_e);
            // The RAM returns whatever the port actually asked for, even across a reset.
            if (en_o[d] === 1'b1) begin
                ram_vld[d][cyc + lat[d]]  = 1'b1;
                ram_addr[d][cyc + lat[d]] = addr_o[d];
            end
            if (grant_e) begin
                sched_idx[d][cyc + lat[d]]  = w;
                sched_addr[d][cyc + lat[d]] = ea;
            end
            if (rst) begin
                for (int c = cyc + 1; c <= cyc + lat[d]; c++) sched_idx[d][c] = -1;
            end
        end
        if (rsp_o[1] === 4'b0010) begin
            rsp_cnt_b++;
            last_rsp_b = cyc;
        end
        if (rst) m_ptr = 0;
        else if (grant_e) m_ptr = (w + 1) % NREQ;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic            rst;
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] prio;
        logic            stall;
        logic [NREQ-1:0] exp_g;
    } vec_t;

    vec_t vt[$];
    int   first_grant_b;

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; m_ptr = 0; rsp_cnt_b = 0; last_rsp_b = 0;
        lat[0] = LA; lat[1] = LB;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < MAXC; c++) begin
                sched_idx[d][c] = -1; sched_addr[d][c] = '0;
                ram_vld[d][c] = 1'b0; ram_addr[d][c] = '0;
            end
        end
        rst = 1'b1; req_en = '0; prio = '0; stall = 1'b0;
        req_addr = {15'h103, 15'h102, 15'h1A5, 15'h100};
        word_in[0] = '0; word_in[1] = '0;
        @(posedge clk);
        #1;

        vt.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000});
        vt.push_back('{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000});
        for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 4'b1111, 4'b0000, 1'b0, NREQ'(1 << (i % 4))});
        for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 4'b0101, 4'b0100, 1'b0, 4'b0100});
        for (int i = 0; i < 4; i++) vt.push_back('{1'b0, 4'b0101, 4'b0000, 1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0100});
        for (int i = 0; i < 3; i++) vt.push_back('{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0000});
        vt.push_back('{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010});
        for (int i = 0; i < 5; i++) vt.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000});
        foreach (vt[i]) begin
            rst = vt[i].rst; req_en = vt[i].req; prio = vt[i].prio; stall = vt[i].stall;
            step(1'b1, vt[i].exp_g, $sformatf("vec%0d", i));
        end

        // Grant to 3 then reset: in-flight read is dropped; a grant to 1 then reset proves ptr clears.
        rst = 1'b0; req_en = 4'b1000; step(1'b1, 4'b1000, "rst_g3");
        rst = 1'b1; req_en = 4'b1111; step(1'b1, 4'b0000, "rst_hold");
        rst = 1'b0; req_en = 4'b0010; step(1'b1, 4'b0010, "rst_g1");
        rst = 1'b1; req_en = 4'b1111; step(1'b1, 4'b0000, "rst_hold2");
        rst = 1'b0; req_en = 4'b1111; step(1'b1, 4'b0001, "rst_restart");
        req_en = 4'b0000;
        for (int i = 0; i < 6; i++) step(1'b1, 4'b0000, "rst_drain");

        // Single requester streaming ten incrementing addresses.
        rsp_cnt_b = 0;
        first_grant_b = cyc;
        req_en = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            req_addr[AW +: AW] = AW'(i);
            step(1'b1, 4'b0010, "stream");
        end
        req_en = 4'b0000;
        for (int i = 0; i < 6; i++) step(1'b1, 4'b0000, "stream_drain");
        check("stream_rsp_count", 64'(rsp_cnt_b), 64'd10);
        check("stream_last_rsp_cycle", 64'(last_rsp_b), 64'(first_grant_b + 9 + LB));

        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            req_en = NREQ'($urandom_range(0, 15));
            prio   = ($urandom_range(0, 2) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
            stall  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 0) req_addr = 60'({$urandom, $urandom});
            step(1'b0, '0, "rand");
        end
        rst = 1'b0; req_en = '0; stall = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, '0, "final_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
